// File: rtl/pipelined_mult_acc.sv
// Elastic multiply pipeline with a registered running accumulator.
// Input register S0, product formed into S1, then pass-through stages to S_LEVEL.
module pipelined_mult_acc #(
    parameter int SIZE  = 8,
    parameter int LEVEL = 3,
    parameter int ACC_W = 2*SIZE+8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    input  logic              signed_mode,
    input  logic              acc_en,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] pdt,
    output logic [ACC_W-1:0]  acc,
    output logic              acc_ovf
);

    localparam int PW = 2*SIZE;

    logic [LEVEL:0]          v_q;
    logic [LEVEL:0]          sm_q;
    logic [LEVEL:0]          en_q;
    logic [LEVEL:0]          clr_q;
    logic [SIZE-1:0]         a_q;
    logic [SIZE-1:0]         b_q;
    logic [LEVEL:1][PW-1:0]  p_q;

    logic [LEVEL:0]          ld;
    logic [LEVEL:0]          adv;
    logic [PW-1:0]           a_x;
    logic [PW-1:0]           b_x;
    logic [PW-1:0]           prod;

    logic [ACC_W-1:0]        acc_q;
    logic                    ovf_q;
    logic [ACC_W-1:0]        ext;
    logic [ACC_W:0]          sum;
    logic                    ovf_add;
    logic                    xfer;

    // Extending both operands to PW bits makes the truncated product exact
    // for either signedness.
    always_comb begin
        a_x  = sm_q[0] ? PW'($signed(a_q)) : PW'(a_q);
        b_x  = sm_q[0] ? PW'($signed(b_q)) : PW'(b_q);
        prod = a_x * b_x;
    end

    // A stage loads when empty or when its content moves on this edge.
    always_comb begin
        adv        = '0;
        ld         = '0;
        adv[LEVEL] = v_q[LEVEL] & out_ready;
        ld[LEVEL]  = ~v_q[LEVEL] | adv[LEVEL];
        for (int k = LEVEL-1; k >= 0; k--) begin
            adv[k] = v_q[k] & ld[k+1];
            ld[k]  = ~v_q[k] | adv[k];
        end
    end

    assign in_ready = ld[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            sm_q  <= '0;
            en_q  <= '0;
            clr_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
        end else begin
            if (ld[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    sm_q[0]  <= signed_mode;
                    en_q[0]  <= acc_en;
                    clr_q[0] <= acc_clr;
                end
            end
            if (ld[1]) begin
                v_q[1] <= v_q[0];
                if (v_q[0]) begin
                    p_q[1]   <= prod;
                    sm_q[1]  <= sm_q[0];
                    en_q[1]  <= en_q[0];
                    clr_q[1] <= clr_q[0];
                end
            end
            for (int k = 2; k <= LEVEL; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        p_q[k]   <= p_q[k-1];
                        sm_q[k]  <= sm_q[k-1];
                        en_q[k]  <= en_q[k-1];
                        clr_q[k] <= clr_q[k-1];
                    end
                end
            end
        end
    end

    // Overflow sense follows the signedness of the product being added.
    always_comb begin
        ext = sm_q[LEVEL] ? ACC_W'($signed(p_q[LEVEL]))
                          : ACC_W'(p_q[LEVEL]);
        sum = {1'b0, acc_q} + {1'b0, ext};
        if (sm_q[LEVEL]) begin
            ovf_add = (acc_q[ACC_W-1] == ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            ovf_add = sum[ACC_W];
        end
    end

    assign xfer = adv[LEVEL];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (xfer) begin
            if (clr_q[LEVEL]) begin
                acc_q <= ext;
                ovf_q <= 1'b0;
            end else if (en_q[LEVEL]) begin
                acc_q <= sum[ACC_W-1:0];
                ovf_q <= ovf_q | ovf_add;
            end
        end
    end

    assign out_valid = v_q[LEVEL];
    assign pdt       = p_q[LEVEL];
    assign acc       = acc_q;
    assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_mult_acc.sv
// Directed bench for pipelined_mult_acc (SIZE=4, LEVEL=2, ACC_W=12).
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_pipelined_mult_acc;

    localparam int SIZE  = 4;
    localparam int LEVEL = 2;
    localparam int ACC_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SIZE-1:0]   a = '0;
    logic [SIZE-1:0]   b = '0;
    logic              signed_mode = 1'b0;
    logic              acc_en = 1'b0;
    logic              acc_clr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2*SIZE-1:0] pdt;
    logic [ACC_W-1:0]  acc;
    logic              acc_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt;
    int first_stall;
    int lat;
    logic [7:0] q[$];
    logic [7:0] bp_exp [8] = '{8'd3, 8'd8, 8'd15, 8'd24,
                               8'd35, 8'd48, 8'd63, 8'd80};

    always #5 clk = ~clk;

    pipelined_mult_acc #(
        .SIZE (SIZE),
        .LEVEL(LEVEL),
        .ACC_W(ACC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .acc_en     (acc_en),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pdt        (pdt),
        .acc        (acc),
        .acc_ovf    (acc_ovf)
    );

    // Record each product that transfers on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) q.push_back(pdt);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present one transaction and hold it until accepted.
    task automatic push(input logic [3:0] ia, input logic [3:0] ib,
                        input logic ism, input logic ien, input logic iclr);
        logic r;
        bit   done;
        done        = 0;
        in_valid    = 1'b1;
        a           = ia;
        b           = ib;
        signed_mode = ism;
        acc_en      = ien;
        acc_clr     = iclr;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            r = in_ready;
            if (!r && first_stall < 0) first_stall = acc_cnt;
            @(posedge clk);
            #1;
            if (r) begin
                done = 1;
                acc_cnt++;
            end
        end
        if (!done) check("push_timeout", 32'(r), 32'd1);
    endtask

    task automatic send_wait(input logic [3:0] ia, input logic [3:0] ib,
                             input logic ism, input logic ien,
                             input logic iclr);
        push(ia, ib, ism, ien, iclr);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        acc_cnt     = 0;
        first_stall = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pdt",       32'(pdt),       32'd0);
        check("rst_acc",       32'(acc),       32'd0);
        check("rst_ovf",       32'(acc_ovf),   32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: accept edge counts as 1, out_valid seen after edge 3.
        q.delete();
        push(4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        check("lat_pdt", 32'(pdt), 32'hE1);
        @(posedge clk);
        #1;

        // Signed versus unsigned interpretation of the same bits.
        repeat (4) @(posedge clk);
        #1;
        q.delete();
        push(4'hF, 4'h7, 1'b1, 1'b0, 1'b0);
        push(4'hF, 4'h7, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("sgn_count", 32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            check("sgn_pdt_s", 32'(q[0]), 32'hF9);
            check("sgn_pdt_u", 32'(q[1]), 32'h69);
        end

        // Backpressure: out_ready low for 5 edges while streaming 8.
        q.delete();
        out_ready   = 1'b0;
        acc_cnt     = 0;
        first_stall = -1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push(4'(i+1), 4'(i+3), 1'b0, 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp_hold_v",   32'(out_valid), 32'd1);
                check("bp_hold_pdt", 32'(pdt),       32'd3);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("bp_first_stall", 32'(first_stall), 32'd3);
        for (int i = 0; i < 40 && q.size() < 8; i++) @(posedge clk);
        #1;
        check("bp_count", 32'(q.size()), 32'd8);
        if (q.size() == 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("bp_pdt%0d", i), 32'(q[i]), 32'(bp_exp[i]));
        end

        // Accumulate: clear-load, add, hold.
        send_wait(4'd3, 4'd5, 1'b0, 1'b0, 1'b1);
        check("acc_clr", 32'(acc), 32'd15);
        send_wait(4'd2, 4'd2, 1'b0, 1'b1, 1'b0);
        check("acc_add", 32'(acc), 32'd19);
        send_wait(4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
        check("acc_hold", 32'(acc), 32'd19);
        check("acc_hold_pdt", 32'(pdt), 32'd49);

        // Unsigned overflow: 19 * 225 = 4275 = 4096 + 179.
        send_wait(4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
        check("ovf_base", 32'(acc), 32'd225);
        check("ovf_base_flag", 32'(acc_ovf), 32'd0);
        for (int i = 0; i < 18; i++) push(4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("ovf_acc",  32'(acc),     32'd179);
        check("ovf_flag", 32'(acc_ovf), 32'd1);
        send_wait(4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        check("ovf_sticky", 32'(acc_ovf), 32'd1);
        check("ovf_sticky_acc", 32'(acc), 32'd179);
        send_wait(4'd1, 4'd1, 1'b0, 1'b0, 1'b1);
        check("ovf_clr_acc",  32'(acc),     32'd1);
        check("ovf_clr_flag", 32'(acc_ovf), 32'd0);

        // Signed: -7 sign-extended, then -7 + -7 carries out but is not
        // a signed overflow.
        send_wait(4'hF, 4'h7, 1'b1, 1'b0, 1'b1);
        check("s_clr_acc", 32'(acc), 32'hFF9);
        send_wait(4'hF, 4'h7, 1'b1, 1'b1, 1'b0);
        check("s_add_acc",  32'(acc),     32'hFF2);
        check("s_add_flag", 32'(acc_ovf), 32'd0);

        // Reset with three transactions in flight.
        out_ready = 1'b0;
        push(4'd3, 4'd3, 1'b0, 1'b1, 1'b0);
        push(4'd4, 4'd4, 1'b0, 1'b1, 1'b0);
        push(4'd5, 4'd5, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pdt",   32'(pdt),       32'd0);
        check("mid_rst_acc",   32'(acc),       32'd0);
        check("mid_rst_ovf",   32'(acc_ovf),   32'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready),  32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("no_stale", 32'(q.size()), 32'd0);
        send_wait(4'd2, 4'd3, 1'b0, 1'b0, 1'b1);
        check("post_rst_acc", 32'(acc), 32'd6);
        check("post_rst_cnt", 32'(q.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
